// File: rtl/regfile_if.sv
// Register file bus: write-back commit port, two decode read ports,
// global ready, and the bring-up status outputs (valid vector, write count).
// The pipeline drives through 'master'; the register file sits on 'slave'.
interface regfile_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_REGS   = 32
);
    logic                  rdy;
    logic                  w_enable;
    logic [ADDR_WIDTH-1:0] waddr;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  r1_enable;
    logic [ADDR_WIDTH-1:0] rs1;
    logic [DATA_WIDTH-1:0] r1_data;
    logic                  r2_enable;
    logic [ADDR_WIDTH-1:0] rs2;
    logic [DATA_WIDTH-1:0] r2_data;
    logic [NUM_REGS-1:0]   reg_valid;
    logic [31:0]           wr_count;

    modport master (
        output rdy, w_enable, waddr, wdata,
        output r1_enable, rs1, r2_enable, rs2,
        input  r1_data, r2_data, reg_valid, wr_count
    );

    modport slave (
        input  rdy, w_enable, waddr, wdata,
        input  r1_enable, rs1, r2_enable, rs2,
        output r1_data, r2_data, reg_valid, wr_count
    );
endinterface

// File: rtl/regfile.sv
// RV32I integer register file: one write-back port, two combinational
// decode read ports, x0 hardwired to zero, per-register "written since
// reset" vector and a committed-write counter.
// Optional macro REGFILE_BYPASS_EN: when defined, a read of the register
// being committed in the same cycle returns the incoming write data; when
// undefined, reads always return the stored (pre-write) value.
module regfile #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_REGS   = 32
) (
    input  logic     clk,
    input  logic     rst,    // asynchronous, active-low
    regfile_if.slave bus
);

    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [NUM_REGS-1:0]   valid_q, valid_d;
    logic [31:0]           wr_count_q, wr_count_d;
    logic                  commit;

    // A write commits only when ready, enabled, in range and not to x0.
    assign commit = bus.rdy && bus.w_enable && (bus.waddr != '0)
                    && (int'(bus.waddr) < NUM_REGS);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
            logic [DATA_WIDTH-1:0] reg_q, reg_d;

            if (gi == 0) begin : g_zero
                // x0 never takes a write; it stays at its reset value of zero.
                always_comb begin
                    reg_d = '0;
                end
            end else begin : g_data
                // Load write data when this register is the commit target.
                always_comb begin
                    reg_d = reg_q;
                    if (commit && (bus.waddr == ADDR_WIDTH'(gi))) begin
                        reg_d = bus.wdata;
                    end
                end
            end

            // Register storage, cleared on reset.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    reg_q <= '0;
                end else begin
                    reg_q <= reg_d;
                end
            end

            assign regs_q[gi] = reg_q;
        end
    endgenerate

    // Valid vector and write counter follow committed writes only.
    always_comb begin
        valid_d    = valid_q;
        wr_count_d = wr_count_q;
        if (commit) begin
            valid_d    = valid_q | (NUM_REGS'(1) << bus.waddr);
            wr_count_d = wr_count_q + 32'd1;
        end
        valid_d[0] = 1'b1;
    end

    // Status state; bit 0 of the valid vector is set out of reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q    <= NUM_REGS'(1);
            wr_count_q <= '0;
        end else begin
            valid_q    <= valid_d;
            wr_count_q <= wr_count_d;
        end
    end

    assign bus.reg_valid = valid_q;
    assign bus.wr_count  = wr_count_q;

    // Read-port priority: reset/not-ready, disabled, x0, bypass, storage.
    function automatic logic [DATA_WIDTH-1:0] read_port(
        input logic                  en,
        input logic [ADDR_WIDTH-1:0] addr
    );
        logic [DATA_WIDTH-1:0] val;
        val = '0;
        if (rst && bus.rdy && en && (addr != '0) && (int'(addr) < NUM_REGS)) begin
`ifdef REGFILE_BYPASS_EN
            if (bus.w_enable && (bus.waddr == addr)) begin
                val = bus.wdata;
            end else begin
                val = regs_q[addr];
            end
`else
            val = regs_q[addr];
`endif
        end
        return val;
    endfunction

    // Both read ports are purely combinational.
    always_comb begin
        bus.r1_data = read_port(bus.r1_enable, bus.rs1);
        bus.r2_data = read_port(bus.r2_enable, bus.rs2);
    end

endmodule

// File: tb/tb_regfile.sv
// Directed bench for regfile: expected values are queued as stimulus is
// driven and popped when the combinational/registered outputs are sampled.
module tb_regfile;

    logic clk;
    logic rst;

    regfile_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_REGS(32)) bus ();

    regfile #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_REGS(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          vectors;
    int          miscompares;
    string       tag_q[$];
    logic [31:0] exp_q[$];

    task automatic expect_val(input string tag, input logic [31:0] val);
        tag_q.push_back(tag);
        exp_q.push_back(val);
    endtask

    task automatic check_val(input logic [31:0] obs);
        string       tag;
        logic [31:0] exp;
        vectors++;
        if (exp_q.size() == 0) begin
            miscompares++;
            $error("FAIL scoreboard_empty observed=%h expected=none", obs);
        end else begin
            tag = tag_q.pop_front();
            exp = exp_q.pop_front();
            assert (obs === exp) else begin
                miscompares++;
                $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
            end
        end
    endtask

    task automatic idle_bus();
        bus.w_enable  = 1'b0;
        bus.waddr     = '0;
        bus.wdata     = '0;
        bus.r1_enable = 1'b0;
        bus.rs1       = '0;
        bus.r2_enable = 1'b0;
        bus.rs2       = '0;
    endtask

    // Commit one write over a full clock edge, then return #1 after it.
    task automatic do_write(input logic [4:0] a, input logic [31:0] d);
        bus.w_enable = 1'b1;
        bus.waddr    = a;
        bus.wdata    = d;
        @(posedge clk);
        #1;
        bus.w_enable = 1'b0;
        $display("write x%0d <= %h", a, d);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b0;
        bus.rdy     = 1'b1;
        idle_bus();

        // Reset state while reset is held
        bus.r1_enable = 1'b1;
        bus.rs1       = 5'd5;
        repeat (2) @(posedge clk);
        #1;
        expect_val("rst_r1_held", 32'h0);       check_val(bus.r1_data);
        expect_val("rst_valid_held", 32'h1);    check_val(bus.reg_valid);
        expect_val("rst_count_held", 32'h0);    check_val(bus.wr_count);
        rst = 1'b1;
        @(posedge clk);
        #1;
        expect_val("rst_r1", 32'h0);            check_val(bus.r1_data);
        expect_val("rst_valid", 32'h1);         check_val(bus.reg_valid);
        expect_val("rst_count", 32'h0);         check_val(bus.wr_count);
        $display("reset released");

        // Write x3 then read on both ports
        do_write(5'd3, 32'hDEADBEEF);
        bus.r1_enable = 1'b1; bus.rs1 = 5'd3;
        bus.r2_enable = 1'b1; bus.rs2 = 5'd3;
        #3;
        expect_val("wr3_r1", 32'hDEADBEEF);     check_val(bus.r1_data);
        expect_val("wr3_r2", 32'hDEADBEEF);     check_val(bus.r2_data);
        expect_val("wr3_valid", 32'h0000_0009); check_val(bus.reg_valid);
        expect_val("wr3_count", 32'd1);         check_val(bus.wr_count);
        $display("read x3 both ports");

        // Same-cycle read of the register being written
        do_write(5'd7, 32'h11);
        bus.w_enable = 1'b1; bus.waddr = 5'd7; bus.wdata = 32'h22;
        bus.r2_enable = 1'b1; bus.rs2 = 5'd7;
        bus.r1_enable = 1'b0; bus.rs1 = 5'd7;
        #3;
`ifdef REGFILE_BYPASS_EN
        expect_val("byp_r2_same", 32'h22);      check_val(bus.r2_data);
`else
        expect_val("byp_r2_same", 32'h11);      check_val(bus.r2_data);
`endif
        expect_val("r1_disabled", 32'h0);       check_val(bus.r1_data);
        @(posedge clk);
        #1;
        bus.w_enable = 1'b0;
        #3;
        expect_val("byp_r2_next", 32'h22);      check_val(bus.r2_data);
        expect_val("byp_count", 32'd3);         check_val(bus.wr_count);
        $display("same-cycle read x7");

        // Write to x0 is discarded
        bus.w_enable = 1'b1; bus.waddr = 5'd0; bus.wdata = 32'hFFFF_FFFF;
        bus.r1_enable = 1'b1; bus.rs1 = 5'd0;
        #3;
        expect_val("x0_same", 32'h0);           check_val(bus.r1_data);
        @(posedge clk);
        #1;
        bus.w_enable = 1'b0;
        #3;
        expect_val("x0_next", 32'h0);           check_val(bus.r1_data);
        expect_val("x0_count", 32'd3);          check_val(bus.wr_count);
        expect_val("x0_valid", 32'h0000_0089);  check_val(bus.reg_valid);
        $display("write x0 ignored");

        // rdy low: no write, reads forced to zero
        bus.rdy = 1'b0;
        bus.w_enable = 1'b1; bus.waddr = 5'd9; bus.wdata = 32'd5;
        bus.r1_enable = 1'b1; bus.rs1 = 5'd3;
        bus.r2_enable = 1'b1; bus.rs2 = 5'd9;
        #3;
        expect_val("rdy0_r1", 32'h0);           check_val(bus.r1_data);
        expect_val("rdy0_r2", 32'h0);           check_val(bus.r2_data);
        @(posedge clk);
        #1;
        bus.rdy = 1'b1;
        bus.w_enable = 1'b0;
        bus.rs1 = 5'd9;
        bus.rs2 = 5'd3;
        #3;
        expect_val("rdy1_r1_x9", 32'h0);        check_val(bus.r1_data);
        expect_val("rdy1_r2_x3", 32'hDEADBEEF); check_val(bus.r2_data);
        expect_val("rdy1_count", 32'd3);        check_val(bus.wr_count);
        expect_val("rdy1_valid", 32'h0000_0089); check_val(bus.reg_valid);
        $display("rdy gating");

        // Writes to x1..x4, then asynchronous reset between edges
        @(posedge clk);
        #1;
        for (int i = 1; i <= 4; i++) begin
            do_write(5'(i), 32'h100 + 32'(i));
        end
        bus.r1_enable = 1'b1; bus.rs1 = 5'd1;
        bus.r2_enable = 1'b1; bus.rs2 = 5'd4;
        #2;
        expect_val("pre_rst_r1", 32'h101);      check_val(bus.r1_data);
        expect_val("pre_rst_r2", 32'h104);      check_val(bus.r2_data);
        expect_val("pre_rst_count", 32'd7);     check_val(bus.wr_count);
        expect_val("pre_rst_valid", 32'h0000_009F); check_val(bus.reg_valid);
        rst = 1'b0;
        #1;
        expect_val("async_r1", 32'h0);          check_val(bus.r1_data);
        expect_val("async_count", 32'd0);       check_val(bus.wr_count);
        expect_val("async_valid", 32'h1);       check_val(bus.reg_valid);
        #1;
        rst = 1'b1;
        #1;
        expect_val("post_rst_r1", 32'h0);       check_val(bus.r1_data);
        expect_val("post_rst_r2", 32'h0);       check_val(bus.r2_data);
        $display("async reset pulse");

        // Normal operation resumes after reset
        @(posedge clk);
        #1;
        do_write(5'd2, 32'h0000_ABCD);
        bus.rs1 = 5'd2;
        #3;
        expect_val("resume_r1", 32'h0000_ABCD); check_val(bus.r1_data);
        expect_val("resume_count", 32'd1);     check_val(bus.wr_count);
        expect_val("resume_valid", 32'h5);      check_val(bus.reg_valid);
        $display("write after reset");

        if (exp_q.size() != 0) begin
            miscompares++;
            $error("FAIL scoreboard_leftover observed=%0d expected=0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
